bypass_nf_back: RTL and testbench
=================================

BYPASS_NF_BACK -- requirements
Module: bypass_nf_back

Interface
REQ-001 SHALL have parameter PKT_W, default 512, packet/usr flit width.
REQ-002 SHALL have parameter EMPTY_W, default 6, empty-byte count width.
REQ-003 SHALL have parameter CNT_W, default 32, packet counter width.
REQ-004 SHALL have ports: Clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: Rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: {nf,bp}_pkt_data / _empty  in  PKT_W / EMPTY_W  NF-processed / bypass packet flits.
REQ-007 SHALL have ports: {nf,bp}_pkt_sop / _eop / _valid  in  1 each  packet framing and valid.
REQ-008 SHALL have ports: {nf,bp}_pkt_ready  out  1  packet backpressure.
REQ-009 SHALL have ports: {nf,bp}_meta_data  in  $bits(metadata_t)  one descriptor per packet.
REQ-010 SHALL have ports: {nf,bp}_meta_valid in 1 / {nf,bp}_meta_ready out 1  meta handshake.
REQ-011 SHALL have ports: {nf,bp}_usr_data / _empty / _sop / _eop / _valid  in  PKT_W / EMPTY_W / 1  one usr message per packet.
REQ-012 SHALL have ports: {nf,bp}_usr_ready  out  1  usr backpressure.
REQ-013 SHALL have ports: out_pkt_data / _empty / _sop / _eop / _valid  out  PKT_W / EMPTY_W / 1  merged packet stream.
REQ-014 SHALL have ports: out_pkt_ready in 1, out_pkt_almost_full in 1  downstream flow control.
REQ-015 SHALL have ports: out_meta_data out $bits(metadata_t), out_meta_valid out 1, out_meta_ready in 1.
REQ-016 SHALL have ports: out_usr_data / _empty / _sop / _eop / _valid  out  PKT_W / EMPTY_W / 1, out_usr_ready in 1.
REQ-017 SHALL have ports: nf_pkt_cnt / bp_pkt_cnt  out  CNT_W  packets forwarded per source.

Function
REQ-018 SHALL merge the NF and bypass paths into the out_* streams at packet granularity; flits of different packets never interleave on any output.
REQ-019 SHALL implement FSM IDLE, META, PKT, USR; sel register (0=nf, 1=bp) chooses the source.
REQ-020 IDLE: SHALL pick a source only when its meta_valid=1 and out_pkt_almost_full=0; if both valid, the source other than last_sel is picked; go to META next cycle.
REQ-021 META: out_meta_data/valid SHALL be driven from a registered copy; the source meta_ready pulses for one cycle on capture; leave META on out_meta_valid & out_meta_ready.
REQ-022 PKT: out_pkt_* = sel source pkt_* combinationally; sel pkt_ready = out_pkt_ready; non-selected ready=0; leave on accepted flit with eop=1.
REQ-023 USR: same pass-through rule on usr channel; on accepted usr eop, SHALL increment the selected counter, set last_sel=sel, and return to IDLE.
REQ-024 Latency: first out_meta_valid SHALL be 2 cycles after meta_valid in IDLE; pkt/usr flits pass with 0-cycle latency.
REQ-025 Single-flit packet (sop=eop=1) SHALL complete PKT in one accepted beat.
REQ-026 Counters SHALL wrap modulo 2^CNT_W without saturation.
REQ-027 Empty and data SHALL pass unmodified; sop/eop SHALL not be checked or repaired.
REQ-028 out_pkt_almost_full SHALL gate only new-packet selection in IDLE, never a packet in progress.

Reset
REQ-029 Rst_n low SHALL asynchronously force FSM=IDLE, sel=0, last_sel=1 (nf wins first tie), counters=0, all out_*_valid=0, all *_ready=0.
REQ-030 Reset mid-packet SHALL abandon the packet; after release, selection restarts from IDLE with no partial flit replayed.

Structure
REQ-031 metadata_t and the FSM state enum SHALL reside in the shared struct package; no new package.
REQ-032 SHALL be a single module; bypass_back_service wraps it with the standard shim instances.

Verification
REQ-033 Only bp: meta+3-flit pkt+1-flit usr -> out_meta once, 3 pkt flits then usr, bp_pkt_cnt=1, nf_pkt_cnt=0.
REQ-034 Both meta_valid from reset -> nf packet first, then bp; counters 1/1.
REQ-035 out_pkt_ready low 5 cycles mid-packet -> output stalls, no flit lost or duplicated, source ready low same cycles.
REQ-036 out_pkt_almost_full=1 in IDLE with meta pending -> no meta_ready until deasserted.
REQ-037 Rst_n low during PKT flit 2 -> all valid/ready 0 immediately; counters 0; next packet forwarded intact.
REQ-038 Counter preloaded to 2^32-1 via force, one packet -> counter reads 0.

Source files
------------

// File: rtl/bypass_nf_back_pkg.sv
// rtl/bypass_nf_back_pkg.sv - shared descriptor and FSM types for the NF/bypass back-end merger
package bypass_nf_back_pkg;

    typedef struct packed {
        logic [31:0] flow_id;
        logic [15:0] pkt_len;
        logic [7:0]  port;
        logic [7:0]  flags;
    } metadata_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_META,
        ST_PKT,
        ST_USR
    } state_t;

    localparam logic SEL_NF = 1'b0;
    localparam logic SEL_BP = 1'b1;

endpackage

// File: rtl/bypass_nf_back_if.sv
// rtl/bypass_nf_back_if.sv - packet/meta/usr channel bundle for one source or sink
interface bypass_nf_back_if
    import bypass_nf_back_pkg::*;
#(
    parameter int PKT_W   = 512,
    parameter int EMPTY_W = 6
) ();

    logic [PKT_W-1:0]   pkt_data;
    logic [EMPTY_W-1:0] pkt_empty;
    logic               pkt_sop;
    logic               pkt_eop;
    logic               pkt_valid;
    logic               pkt_ready;

    metadata_t          meta_data;
    logic               meta_valid;
    logic               meta_ready;

    logic [PKT_W-1:0]   usr_data;
    logic [EMPTY_W-1:0] usr_empty;
    logic               usr_sop;
    logic               usr_eop;
    logic               usr_valid;
    logic               usr_ready;

    modport master (
        output pkt_data, pkt_empty, pkt_sop, pkt_eop, pkt_valid,
        output meta_data, meta_valid,
        output usr_data, usr_empty, usr_sop, usr_eop, usr_valid,
        input  pkt_ready, meta_ready, usr_ready
    );

    modport slave (
        input  pkt_data, pkt_empty, pkt_sop, pkt_eop, pkt_valid,
        input  meta_data, meta_valid,
        input  usr_data, usr_empty, usr_sop, usr_eop, usr_valid,
        output pkt_ready, meta_ready, usr_ready
    );

endinterface

// File: rtl/bypass_nf_back.sv
// rtl/bypass_nf_back.sv - packet-granular merge of the NF and bypass paths onto one output
module bypass_nf_back
    import bypass_nf_back_pkg::*;
#(
    parameter int PKT_W   = 512,
    parameter int EMPTY_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    bypass_nf_back_if.slave  nf,
    bypass_nf_back_if.slave  bp,
    bypass_nf_back_if.master out,
    input  logic             out_pkt_almost_full,
    output logic [CNT_W-1:0] nf_pkt_cnt,
    output logic [CNT_W-1:0] bp_pkt_cnt
);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_sel_q;
    metadata_t        meta_q;
    logic             meta_vld_q;
    logic [CNT_W-1:0] nf_cnt_q, bp_cnt_q;
    logic             meta_cap, usr_done;
    logic             nf_req, bp_req;

    logic [PKT_W-1:0]   src_pkt_data, src_usr_data;
    logic [EMPTY_W-1:0] src_pkt_empty, src_usr_empty;
    logic               src_pkt_sop, src_pkt_eop, src_pkt_valid;
    logic               src_usr_sop, src_usr_eop, src_usr_valid;
    metadata_t          src_meta_data;
    logic               src_meta_valid;

    assign src_pkt_data   = sel_q ? bp.pkt_data   : nf.pkt_data;
    assign src_pkt_empty  = sel_q ? bp.pkt_empty  : nf.pkt_empty;
    assign src_pkt_sop    = sel_q ? bp.pkt_sop    : nf.pkt_sop;
    assign src_pkt_eop    = sel_q ? bp.pkt_eop    : nf.pkt_eop;
    assign src_pkt_valid  = sel_q ? bp.pkt_valid  : nf.pkt_valid;
    assign src_usr_data   = sel_q ? bp.usr_data   : nf.usr_data;
    assign src_usr_empty  = sel_q ? bp.usr_empty  : nf.usr_empty;
    assign src_usr_sop    = sel_q ? bp.usr_sop    : nf.usr_sop;
    assign src_usr_eop    = sel_q ? bp.usr_eop    : nf.usr_eop;
    assign src_usr_valid  = sel_q ? bp.usr_valid  : nf.usr_valid;
    assign src_meta_data  = sel_q ? bp.meta_data  : nf.meta_data;
    assign src_meta_valid = sel_q ? bp.meta_valid : nf.meta_valid;

    // Payload always follows sel; only the valids are gated by state.
    assign out.pkt_data   = src_pkt_data;
    assign out.pkt_empty  = src_pkt_empty;
    assign out.pkt_sop    = src_pkt_sop;
    assign out.pkt_eop    = src_pkt_eop;
    assign out.usr_data   = src_usr_data;
    assign out.usr_empty  = src_usr_empty;
    assign out.usr_sop    = src_usr_sop;
    assign out.usr_eop    = src_usr_eop;
    assign out.meta_data  = meta_q;
    assign out.meta_valid = meta_vld_q;

    assign nf_pkt_cnt = nf_cnt_q;
    assign bp_pkt_cnt = bp_cnt_q;

    // almost_full only blocks starting a new packet
    assign nf_req = nf.meta_valid & ~out_pkt_almost_full;
    assign bp_req = bp.meta_valid & ~out_pkt_almost_full;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        meta_cap      = 1'b0;
        usr_done      = 1'b0;
        nf.meta_ready = 1'b0;
        bp.meta_ready = 1'b0;
        nf.pkt_ready  = 1'b0;
        bp.pkt_ready  = 1'b0;
        nf.usr_ready  = 1'b0;
        bp.usr_ready  = 1'b0;
        out.pkt_valid = 1'b0;
        out.usr_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (nf_req && bp_req) begin
                    sel_d   = ~last_sel_q;
                    state_d = ST_META;
                end else if (nf_req) begin
                    sel_d   = SEL_NF;
                    state_d = ST_META;
                end else if (bp_req) begin
                    sel_d   = SEL_BP;
                    state_d = ST_META;
                end
            end
            ST_META: begin
                if (!meta_vld_q) begin
                    if (sel_q) bp.meta_ready = 1'b1;
                    else       nf.meta_ready = 1'b1;
                    meta_cap = src_meta_valid;
                end else if (out.meta_ready) begin
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                out.pkt_valid = src_pkt_valid;
                if (sel_q) bp.pkt_ready = out.pkt_ready;
                else       nf.pkt_ready = out.pkt_ready;
                if (src_pkt_valid && out.pkt_ready && src_pkt_eop) state_d = ST_USR;
            end
            ST_USR: begin
                out.usr_valid = src_usr_valid;
                if (sel_q) bp.usr_ready = out.usr_ready;
                else       nf.usr_ready = out.usr_ready;
                if (src_usr_valid && out.usr_ready && src_usr_eop) begin
                    usr_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_NF;
            last_sel_q <= SEL_BP;
            meta_q     <= '0;
            meta_vld_q <= 1'b0;
            nf_cnt_q   <= '0;
            bp_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (meta_cap) begin
                meta_q     <= src_meta_data;
                meta_vld_q <= 1'b1;
            end else if (meta_vld_q && out.meta_ready) begin
                meta_vld_q <= 1'b0;
            end
            if (usr_done) begin
                last_sel_q <= sel_q;
                if (sel_q) bp_cnt_q <= bp_cnt_q + CNT_W'(1);
                else       nf_cnt_q <= nf_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bypass_nf_back.sv
// tb/tb_bypass_nf_back.sv - scoreboard bench for the NF/bypass back-end merger
module tb_bypass_nf_back;
    import bypass_nf_back_pkg::*;

    localparam int PW  = 64;
    localparam int EW  = 3;
    localparam int CW  = 32;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst_n;
    logic af;
    logic [CW-1:0] nf_cnt, bp_cnt;

    bypass_nf_back_if #(.PKT_W(PW), .EMPTY_W(EW)) nf_if ();
    bypass_nf_back_if #(.PKT_W(PW), .EMPTY_W(EW)) bp_if ();
    bypass_nf_back_if #(.PKT_W(PW), .EMPTY_W(EW)) out_if ();

    bypass_nf_back #(.PKT_W(PW), .EMPTY_W(EW), .CNT_W(CW)) dut (
        .Clk(clk), .Rst_n(rst_n), .nf(nf_if), .bp(bp_if), .out(out_if),
        .out_pkt_almost_full(af), .nf_pkt_cnt(nf_cnt), .bp_pkt_cnt(bp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] data;
        logic [2:0]  empty;
        logic        sop;
        logic        eop;
    } exp_t;

    typedef struct {
        bit src;
        int id;
        int np;
        int nu;
        int exp_nf;
        int exp_bp;
    } vec_t;

    exp_t q[$];
    vec_t vecs[4];
    int   checks   = 0;
    int   failures = 0;
    int   pkt_beats = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [63:0] flit(input bit src, input int id, input int ch, input int i);
        return {(src ? 8'hB0 : 8'hA0), id[7:0], ch[7:0], i[7:0], 32'hC0DE_0000 + i[31:0]};
    endfunction

    function automatic logic [63:0] mk_meta(input bit src, input int id);
        return {16'hFEED, id[15:0], 24'h0, 7'h0, src};
    endfunction

    function automatic void push_item(input int kind, input logic [63:0] d,
                                      input logic [2:0] e, input logic s, input logic eo);
        exp_t x;
        x.kind = kind; x.data = d; x.empty = e; x.sop = s; x.eop = eo;
        q.push_back(x);
    endfunction

    function automatic void push_pkt(input bit src, input int id, input int np, input int nu);
        push_item(0, mk_meta(src, id), 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < np; i++)
            push_item(1, flit(src, id, 1, i), i[2:0], i == 0, i == np - 1);
        for (int i = 0; i < nu; i++)
            push_item(2, flit(src, id, 2, i), i[2:0], i == 0, i == nu - 1);
    endfunction

    function automatic void set_meta(input bit src, input logic v, input logic [63:0] d);
        if (src) begin bp_if.meta_valid = v; bp_if.meta_data = d; end
        else     begin nf_if.meta_valid = v; nf_if.meta_data = d; end
    endfunction

    function automatic void set_flit(input bit src, input int ch, input logic v, input logic [63:0] d,
                                     input logic [2:0] e, input logic s, input logic eo);
        if (src && ch == 1) begin
            bp_if.pkt_valid = v; bp_if.pkt_data = d; bp_if.pkt_empty = e; bp_if.pkt_sop = s; bp_if.pkt_eop = eo;
        end else if (src) begin
            bp_if.usr_valid = v; bp_if.usr_data = d; bp_if.usr_empty = e; bp_if.usr_sop = s; bp_if.usr_eop = eo;
        end else if (ch == 1) begin
            nf_if.pkt_valid = v; nf_if.pkt_data = d; nf_if.pkt_empty = e; nf_if.pkt_sop = s; nf_if.pkt_eop = eo;
        end else begin
            nf_if.usr_valid = v; nf_if.usr_data = d; nf_if.usr_empty = e; nf_if.usr_sop = s; nf_if.usr_eop = eo;
        end
    endfunction

    function automatic logic get_ready(input bit src, input int ch);
        case (ch)
            0:       return src ? bp_if.meta_ready : nf_if.meta_ready;
            1:       return src ? bp_if.pkt_ready  : nf_if.pkt_ready;
            default: return src ? bp_if.usr_ready  : nf_if.usr_ready;
        endcase
    endfunction

    task automatic wait_rdy(input bit src, input int ch, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (get_ready(src, ch)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send(input bit src, input int id, input int np, input int nu);
        bit ok;
        set_meta(src, 1'b1, mk_meta(src, id));
        wait_rdy(src, 0, ok);
        @(posedge clk); #1;
        set_meta(src, 1'b0, 64'h0);
        if (!ok) begin check(1'b0, "meta_ready_wait", 64'(id), 64'(src)); return; end
        for (int ch = 1; ch <= 2; ch++) begin
            int n;
            n = (ch == 1) ? np : nu;
            for (int i = 0; i < n; i++) begin
                set_flit(src, ch, 1'b1, flit(src, id, ch, i), i[2:0], i == 0, i == n - 1);
                wait_rdy(src, ch, ok);
                @(posedge clk); #1;
                if (!ok) begin
                    set_flit(src, ch, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
                    check(1'b0, "flit_ready_wait", 64'(i), 64'(ch));
                    return;
                end
            end
            set_flit(src, ch, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic take(input int kind, input logic [63:0] d, input logic [2:0] e,
                        input logic s, input logic eo);
        exp_t x;
        if (q.size() == 0) begin
            check(1'b0, "unexpected_beat", d, 64'(kind));
        end else begin
            x = q.pop_front();
            check(x.kind == kind && x.data == d && x.empty == e && x.sop == s && x.eop == eo,
                  $sformatf("out_beat_kind%0d_sop%0b_eop%0b_empty%0d", kind, s, eo, e), d, x.data);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_if.meta_valid && out_if.meta_ready)
                    take(0, out_if.meta_data, 3'd0, 1'b0, 1'b0);
                if (out_if.pkt_valid && out_if.pkt_ready) begin
                    pkt_beats++;
                    take(1, out_if.pkt_data, out_if.pkt_empty, out_if.pkt_sop, out_if.pkt_eop);
                end
                if (out_if.usr_valid && out_if.usr_ready)
                    take(2, out_if.usr_data, out_if.usr_empty, out_if.usr_sop, out_if.usr_eop);
            end
        end
    endtask

    task automatic check_cnts(input string name, input int enf, input int ebp);
        check(nf_cnt == CW'(enf), {name, "_nf_cnt"}, 64'(nf_cnt), 64'(enf));
        check(bp_cnt == CW'(ebp), {name, "_bp_cnt"}, 64'(bp_cnt), 64'(ebp));
    endtask

    task automatic check_quiet(input string name);
        check(!out_if.pkt_valid && !out_if.meta_valid && !out_if.usr_valid, {name, "_out_valids"},
              {61'h0, out_if.pkt_valid, out_if.meta_valid, out_if.usr_valid}, 64'h0);
        check(!nf_if.meta_ready && !nf_if.pkt_ready && !nf_if.usr_ready &&
              !bp_if.meta_ready && !bp_if.pkt_ready && !bp_if.usr_ready, {name, "_readies"},
              {58'h0, nf_if.meta_ready, nf_if.pkt_ready, nf_if.usr_ready,
               bp_if.meta_ready, bp_if.pkt_ready, bp_if.usr_ready}, 64'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base;
        rst_n = 1'b0; af = 1'b0;
        set_meta(1'b0, 1'b0, 64'h0); set_meta(1'b1, 1'b0, 64'h0);
        for (int s = 0; s < 2; s++)
            for (int ch = 1; ch <= 2; ch++) set_flit(s[0], ch, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
        out_if.pkt_ready = 1'b1; out_if.meta_ready = 1'b1; out_if.usr_ready = 1'b1;

        vecs[0] = '{src: 1'b1, id: 1, np: 3, nu: 1, exp_nf: 0, exp_bp: 1};
        vecs[1] = '{src: 1'b0, id: 2, np: 1, nu: 1, exp_nf: 1, exp_bp: 1};
        vecs[2] = '{src: 1'b0, id: 3, np: 2, nu: 3, exp_nf: 2, exp_bp: 1};
        vecs[3] = '{src: 1'b1, id: 4, np: 5, nu: 2, exp_nf: 2, exp_bp: 2};

        fork monitor(); join_none

        repeat (3) @(posedge clk); #1;
        check_quiet("reset");
        check_cnts("reset", 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            push_pkt(vecs[v].src, vecs[v].id, vecs[v].np, vecs[v].nu);
            send(vecs[v].src, vecs[v].id, vecs[v].np, vecs[v].nu);
            check_cnts($sformatf("vec%0d", v), vecs[v].exp_nf, vecs[v].exp_bp);
        end

        // tie straight out of reset: nf first, then bp
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        check_cnts("tie_reset", 0, 0);
        push_pkt(1'b0, 10, 2, 1);
        push_pkt(1'b1, 11, 2, 1);
        fork
            send(1'b0, 10, 2, 1);
            send(1'b1, 11, 2, 1);
        join
        check_cnts("tie", 1, 1);

        // downstream stall mid-packet
        base = pkt_beats;
        push_pkt(1'b1, 20, 6, 1);
        fork
            send(1'b1, 20, 6, 1);
            begin
                for (int n = 0; n < TMO && pkt_beats < base + 2; n++) @(posedge clk);
                check(pkt_beats >= base + 2, "stall_start_wait", 64'(pkt_beats), 64'(base + 2));
                #1 out_if.pkt_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check(!bp_if.pkt_ready, "stall_src_ready", 64'(bp_if.pkt_ready), 64'h0);
                    check(out_if.pkt_valid && out_if.pkt_data == flit(1'b1, 20, 1, 2),
                          "stall_out_hold", out_if.pkt_data, flit(1'b1, 20, 1, 2));
                end
                @(posedge clk); #1 out_if.pkt_ready = 1'b1;
            end
        join
        check_cnts("stall", 1, 2);

        // almost_full holds back selection
        af = 1'b1;
        push_pkt(1'b0, 30, 1, 1);
        fork
            send(1'b0, 30, 1, 1);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    check(!nf_if.meta_ready && !out_if.meta_valid, "af_gate",
                          {62'h0, nf_if.meta_ready, out_if.meta_valid}, 64'h0);
                end
                @(posedge clk); #1 af = 1'b0;
            end
        join
        check_cnts("af", 2, 2);

        // reset while the second flit of a bp packet is on the wire
        push_item(0, mk_meta(1'b1, 40), 3'd0, 1'b0, 1'b0);
        push_item(1, flit(1'b1, 40, 1, 0), 3'd0, 1'b1, 1'b0);
        set_meta(1'b1, 1'b1, mk_meta(1'b1, 40));
        wait_rdy(1'b1, 0, ok);
        check(ok, "rst_meta_wait", 64'(ok), 64'h1);
        @(posedge clk); #1;
        set_meta(1'b1, 1'b0, 64'h0);
        set_flit(1'b1, 1, 1'b1, flit(1'b1, 40, 1, 0), 3'd0, 1'b1, 1'b0);
        wait_rdy(1'b1, 1, ok);
        check(ok, "rst_flit0_wait", 64'(ok), 64'h1);
        @(posedge clk); #1;
        set_flit(1'b1, 1, 1'b1, flit(1'b1, 40, 1, 1), 3'd1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_quiet("mid_pkt_reset");
        check_cnts("mid_pkt_reset", 0, 0);
        check(q.size() == 0, "mid_pkt_reset_drained", 64'(q.size()), 64'h0);
        set_flit(1'b1, 1, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push_pkt(1'b1, 41, 3, 1);
        send(1'b1, 41, 3, 1);
        check_cnts("after_reset", 0, 1);

        // counter wrap
        @(negedge clk);
        force dut.bp_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.bp_cnt_q;
        @(posedge clk); #1;
        check(bp_cnt == 32'hFFFF_FFFF, "wrap_preload", 64'(bp_cnt), 64'hFFFF_FFFF);
        push_pkt(1'b1, 50, 2, 1);
        send(1'b1, 50, 2, 1);
        check_cnts("wrap", 0, 0);

        repeat (2) @(posedge clk);
        check(q.size() == 0, "scoreboard_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
